// File: rtl/spi_rx_pkg.sv
// Shared constants and types for the SPI receive block: field layout of the
// CPU-visible status word, command bits, FSM encoding and bus address.
package spi_rx_pkg;

  localparam int unsigned DEPTH = 4;

  localparam int unsigned BYTE_LSB  = 0;
  localparam int unsigned DC_BIT    = 8;
  localparam int unsigned VALID_BIT = 9;
  localparam int unsigned OVR_BIT   = 10;
  localparam int unsigned FERR_BIT  = 11;

  localparam int unsigned WDATA_POP = 0;
  localparam int unsigned WDATA_CLR = 1;

  localparam logic [31:0] SPI_RX_ADDR = 32'hff20;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // {dc, byte[7:0]}
  typedef logic [8:0] entry_t;

endpackage

// File: rtl/spi_rx_if.sv
// Pin and CPU-side signals of the SPI receiver, bundled for the top level.
interface spi_rx_if;
  logic        sck_in;
  logic        cs_in_;
  logic        sdi_in;
  logic        dc_in;
  logic        we;
  logic [1:0]  wdata;
  logic [31:0] rdata;

  modport slave (
    input  sck_in, cs_in_, sdi_in, dc_in, we, wdata,
    output rdata
  );

  modport master (
    output sck_in, cs_in_, sdi_in, dc_in, we, wdata,
    input  rdata
  );
endinterface

// File: rtl/spi_rx_fifo.sv
// Circular buffer of received {dc, byte} entries. A push while full is dropped
// and flagged, unless a pop in the same cycle makes room.
module spi_rx_fifo
  import spi_rx_pkg::*;
#(
  parameter int unsigned Depth = DEPTH,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  entry_t          push_data_i,
  input  logic            pop_i,
  output entry_t          head_o,
  output logic [CntW-1:0] count_o,
  output logic            overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              full, empty, do_push, do_pop;

  always_comb begin
    full       = (count_q == CntW'(Depth));
    empty      = (count_q == '0);
    do_pop     = pop_i && !empty;
    do_push    = push_i && (!full || do_pop);
    overflow_o = push_i && full && !do_pop;
    head_o     = empty ? '0 : mem_q[rd_ptr_q];
    count_o    = count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: empty entries are masked on the head output.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/spi_rx.sv
// Mode 3 SPI slave receiver: synchronizes the pins, assembles MSB-first bytes
// with their D/C flag and queues them for the CPU, with sticky error flags.
module spi_rx
  import spi_rx_pkg::*;
#(
  parameter int unsigned Depth = DEPTH
) (
  input logic     clk,
  input logic     reset,
  spi_rx_if.slave bus
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic cs_s1_q, cs_s2_q, sdi_s1_q, sdi_s2_q, dc_s1_q, dc_s2_q;

  state_e      state_q;
  logic [2:0]  bitcnt_q;
  logic [6:0]  shreg_q;
  logic        ferr_q, ovr_q;

  logic            rise, push, ferr_set, pop, clr, overflow;
  entry_t          push_data, head;
  logic [CntW-1:0] count;

  always_comb begin
    rise      = sck_s2_q & ~sck_s3_q;
    push      = (state_q == StShift) && rise && (bitcnt_q == 3'd7);
    push_data = {dc_s2_q, shreg_q, sdi_s2_q};
    // A rise coinciding with cs deassertion counts before the partial-byte test.
    ferr_set  = (state_q == StShift) && cs_s2_q &&
                (rise ? (bitcnt_q != 3'd7) : (bitcnt_q != 3'd0));
    pop       = bus.we && bus.wdata[WDATA_POP];
    clr       = bus.we && bus.wdata[WDATA_CLR];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_s1_q <= 1'b1;
      sck_s2_q <= 1'b1;
      sck_s3_q <= 1'b1;
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      sdi_s1_q <= 1'b0;
      sdi_s2_q <= 1'b0;
      dc_s1_q  <= 1'b0;
      dc_s2_q  <= 1'b0;
      state_q  <= StIdle;
      bitcnt_q <= '0;
      shreg_q  <= '0;
    end else begin
      sck_s1_q <= bus.sck_in;
      sck_s2_q <= sck_s1_q;
      sck_s3_q <= sck_s2_q;
      cs_s1_q  <= bus.cs_in_;
      cs_s2_q  <= cs_s1_q;
      sdi_s1_q <= bus.sdi_in;
      sdi_s2_q <= sdi_s1_q;
      dc_s1_q  <= bus.dc_in;
      dc_s2_q  <= dc_s1_q;
      unique case (state_q)
        StIdle: begin
          if (!cs_s2_q) begin
            state_q  <= StShift;
            bitcnt_q <= '0;
          end
        end
        StShift: begin
          if (rise) begin
            shreg_q  <= {shreg_q[5:0], sdi_s2_q};
            bitcnt_q <= bitcnt_q + 3'd1;
          end
          if (cs_s2_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (ferr_set)  ferr_q <= 1'b1;
      else if (clr)  ferr_q <= 1'b0;
      if (overflow)  ovr_q  <= 1'b1;
      else if (clr)  ovr_q  <= 1'b0;
    end
  end

  spi_rx_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .overflow_o  (overflow)
  );

  always_comb begin
    bus.rdata                   = '0;
    bus.rdata[BYTE_LSB +: 8]    = head[7:0];
    bus.rdata[DC_BIT]           = head[8];
    bus.rdata[VALID_BIT]        = (count != '0);
    bus.rdata[OVR_BIT]          = ovr_q;
    bus.rdata[FERR_BIT]         = ferr_q;
  end

endmodule
